read_burst_ctrl: RTL
====================

READ_BURST_CTRL -- requirements
Module: read_burst_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, asynchronous, active-low.
REQ-003 reqN_valid (N=0,1)  in  1  requester N has a pending burst read.
REQ-004 reqN_addr  in  32  burst base byte address; bits[1:0] ignored and treated as 0.
REQ-005 reqN_len  in  2  burst length minus one (0..3 means 1..4 words).
REQ-006 reqN_ready  out  1  one-cycle pulse; request N accepted this cycle.
REQ-007 bus_read_req  out  1  word read request to the memory bus.
REQ-008 bus_addr  out  32  word address of the current bus request; bits[1:0]=0.
REQ-009 bus_ready  in  1  bus accepts the request when bus_read_req&&bus_ready.
REQ-010 bus_read_data / bus_read_data_valid  in  32 / 1  returned read word; in-order, one per accepted request.
REQ-011 buf_clear  out  1  clear strobe to the 4-word read buffer.
REQ-012 buf_read_data / buf_read_data_valid  out  32 / 1  word and write strobe to the read buffer.
REQ-013 done  out  1  one-cycle pulse; burst complete, read buffer holds len+1 words.
REQ-014 done_id  out  1  requester of the completing burst; valid when done=1.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, ISSUE, WAIT, DONE; one-hot or encoded at implementer's choice.
REQ-017 IDLE, no reqN_valid: stay IDLE; all strobes 0.
REQ-018 IDLE, exactly one reqN_valid: grant N; reqN_ready=1 and buf_clear=1 that cycle.
REQ-019 IDLE, both valid: round-robin; grant the requester not granted last; the granted requester is recorded as last_grant.
REQ-020 Accept cycle: latch addr, len, id; clear issued and returned counters (3 bits each, range 0..4); next state ISSUE.
REQ-021 ISSUE: bus_read_req=1, bus_addr = base + 4*issued, modulo 2^32.
REQ-022 issued increments on each bus_read_req&&bus_ready; after the (len+1)th acceptance, bus_read_req=0 from the next cycle.
REQ-023 Leave ISSUE when issued reaches len+1: go to DONE if returned already equals len+1 (counting a return in the same cycle), else go to WAIT.
REQ-024 In ISSUE or WAIT, bus_read_data_valid=1: buf_read_data_valid=1 and buf_read_data=bus_read_data in the same cycle (combinational); returned increments.
REQ-025 WAIT: go to DONE on the cycle returned reaches len+1.
REQ-026 Returns may arrive in ISSUE before all addresses issue; returns and issues in the same cycle both count.
REQ-027 DONE: done=1, done_id=latched id, for exactly one cycle; next state IDLE.
REQ-028 Latency: accept at cycle T -> bus_read_req first high at T+1; last data at cycle D -> done at D+1; next accept possible at D+2.
REQ-029 bus_read_data_valid in IDLE or DONE: ignored; buf_read_data_valid stays 0.
REQ-030 reqN_addr, reqN_len and reqN_valid changes after acceptance do not affect the burst in flight.

Reset
REQ-031 reset_n low, at any time including mid-burst: state=IDLE; counters=0; latched addr/len/id=0; last_grant=1, so req0 wins the first tie.
REQ-032 Output values during reset: reqN_ready, bus_read_req, bus_addr, buf_clear, buf_read_data_valid, buf_read_data, done, done_id and busy all 0.
REQ-033 Reads outstanding at reset are abandoned; their returns are ignored under REQ-029.

Verification
REQ-034 Sequence: req0 addr=0x1000, len=3, bus_ready=1, 2-cycle data latency.
- Required: bus_addr 0x1000/0x1004/0x1008/0x100C on 4 consecutive cycles.
- Required: 4 buf_read_data_valid pulses, then done=1 with done_id=0.
REQ-035 Sequence: after reset, req0 and req1 both held valid.
- Required: grants in order req0, req1, req0.
- Required: reqN_ready and buf_clear pulse once per grant.
REQ-036 Sequence: req1 addr=0xFFFFFFF8, len=3.
- Required: bus_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-037 Sequence: len=0, bus_ready low for 3 cycles, data returns in the same cycle as acceptance.
- Required: bus_read_req held high with a stable address while bus_ready is low.
- Required: done exactly 1 cycle after the data.
REQ-038 Sequence: reset_n pulsed low after 2 of 4 issues; later returns arrive in IDLE.
- Required: all outputs 0, busy=0.
- Required: no buf_read_data_valid pulses.
- Required: a new req1 is then accepted normally.

Source files
------------

// File: rtl/read_burst_ctrl.sv
// Two-requester burst read controller: arbitrates round-robin, issues up to four word
// reads to the memory bus and forwards returned words to a 4-word read buffer.
module read_burst_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic [31:0] req0_addr,
   input  logic [1:0]  req0_len,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_addr,
   input  logic [1:0]  req1_len,
   output logic        req1_ready,
   output logic        bus_read_req,
   output logic [31:0] bus_addr,
   input  logic        bus_ready,
   input  logic [31:0] bus_read_data,
   input  logic        bus_read_data_valid,
   output logic        buf_clear,
   output logic [31:0] buf_read_data,
   output logic        buf_read_data_valid,
   output logic        done,
   output logic        done_id,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

   state_t      state;
   logic [31:0] base_addr;
   logic [1:0]  len;
   logic        id;
   logic        last_grant;
   logic [2:0]  issued;
   logic [2:0]  returned;

   logic        grant_any;
   logic        grant_id;
   logic        issue_fire;
   logic        ret_fire;
   logic [2:0]  words;
   logic [2:0]  issued_nxt;
   logic [2:0]  returned_nxt;

   // Grant is gated by reset_n so no strobe escapes while reset is held.
   always_comb begin
      grant_any    = (state == StIdle) && reset_n && (req0_valid || req1_valid);
      grant_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      issue_fire   = (state == StIssue) && bus_ready;
      ret_fire     = ((state == StIssue) || (state == StWait)) && bus_read_data_valid;
      words        = {1'b0, len} + 3'd1;
      issued_nxt   = issued + {2'b00, issue_fire};
      returned_nxt = returned + {2'b00, ret_fire};
   end

   always_comb begin
      req0_ready          = grant_any && !grant_id;
      req1_ready          = grant_any && grant_id;
      buf_clear           = grant_any;
      bus_read_req        = (state == StIssue);
      bus_addr            = bus_read_req ? base_addr + {27'd0, issued, 2'b00} : 32'd0;
      buf_read_data_valid = ret_fire;
      buf_read_data       = ret_fire ? bus_read_data : 32'd0;
      done                = (state == StDone);
      done_id             = (state == StDone) && id;
      busy                = (state != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= StIdle;
         base_addr  <= 32'd0;
         len        <= 2'd0;
         id         <= 1'b0;
         last_grant <= 1'b1;
         issued     <= 3'd0;
         returned   <= 3'd0;
      end else begin
         unique case (state)
            StIdle: begin
               if (grant_any) begin
                  base_addr  <= (grant_id ? req1_addr : req0_addr) & ~32'h3;
                  len        <= grant_id ? req1_len : req0_len;
                  id         <= grant_id;
                  last_grant <= grant_id;
                  issued     <= 3'd0;
                  returned   <= 3'd0;
                  state      <= StIssue;
               end
            end
            StIssue: begin
               issued   <= issued_nxt;
               returned <= returned_nxt;
               // A return landing with the final issue can skip WAIT entirely.
               if (issue_fire && (issued_nxt == words)) begin
                  state <= (returned_nxt == words) ? StDone : StWait;
               end
            end
            StWait: begin
               returned <= returned_nxt;
               if (returned_nxt == words) begin
                  state <= StDone;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
